// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared types for the instruction cache (address split, frame, FSM).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int ICACHE_SETS = 16;
    localparam int IDX_W       = $clog2(ICACHE_SETS);
    localparam int ITAG_W      = 30 - IDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IDX_W-1:0]  idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module : icache
// Brief  : Direct-mapped, one-word-per-block instruction cache. Same-cycle hits,
//          single-word fill on miss. Optional counters with ICACHE_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS   // must equal 2**IDX_W from the package
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    icachef_t      addr_w;
    icache_frame_t frame_w;
    icache_frame_t frames_q [SETS];
    icache_state_t state_q, state_d;
    logic          hit_w;
    logic          fill_w;

    assign addr_w  = icachef_t'(imemaddr);
    assign frame_w = frames_q[addr_w.idx];
    assign hit_w   = imemREN & frame_w.valid & (frame_w.tag == addr_w.tag);

    // Memory is word addressed: the byte offset is forced to zero.
    assign iaddr   = {addr_w.tag, addr_w.idx, addr_w.bytoff & 2'b00};

    always_comb begin
        state_d  = state_q;
        ihit     = 1'b0;
        imemload = 32'h0;
        iREN     = 1'b0;
        fill_w   = 1'b0;
        case (state_q)
            IDLE: begin
                ihit     = hit_w;
                imemload = hit_w ? frame_w.data : 32'h0;
                if (imemREN && !hit_w)
                    state_d = MISS;
            end
            MISS: begin
                iREN = imemREN;
                if (!imemREN) begin
                    state_d = IDLE;
                end else if (!iwait) begin
                    fill_w  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset silences the fetch port immediately and aborts any fill.
        if (RST) begin
            ihit     = 1'b0;
            imemload = 32'h0;
            iREN     = 1'b0;
            fill_w   = 1'b0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            for (int i = 0; i < SETS; i++)
                frames_q[i].valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fill_w)
                frames_q[addr_w.idx] <= '{valid: 1'b1, tag: addr_w.tag, data: iload};
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (state_q == IDLE && ihit)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && state_d == MISS)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

`default_nettype wire
